mem_port_arbiter: RTL and testbench

- Arbitrates the single-ported unified memory between the instruction-fetch (IF) requester and the data-access (MEM stage) requester.
- Sequences each access through a request/acknowledge handshake with the memory.
- Drives the select of the N-bit 2:1 address/write-data mux in front of the memory port.
- Issues stall signals back to the pipeline hazard logic.
- Data accesses have priority; a bounded starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch and data access.
// Data accesses win by default; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int CNT_W        = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inst_req,
  input  logic data_req,
  input  logic data_we,
  output logic mem_req,
  output logic mem_we,
  output logic mem_sel,
  input  logic mem_ack,
  output logic inst_done,
  output logic data_done,
  output logic inst_stall,
  output logic data_stall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, cnt_nxt;
  logic             req_nxt, we_nxt, sel_nxt;
  logic             grant_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (int'(c) >= STARVE_LIMIT) return LIMIT;
    return c + CNT_W'(1);
  endfunction

  // Data wins unless fetch has already been passed over STARVE_LIMIT times in a row
  assign grant_data = data_req && (!inst_req || (int'(starve_cnt) < STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      mem_req    <= req_nxt;
      mem_we     <= we_nxt;
      mem_sel    <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    sel_nxt   = mem_sel;
    case (state)
      IDLE: begin
        // A stale mem_ack here is deliberately ignored
        if (grant_data) begin
          state_nxt = DATA;
          req_nxt   = 1'b1;
          sel_nxt   = 1'b1;
          we_nxt    = data_we;
          cnt_nxt   = inst_req ? sat_inc(starve_cnt) : '0;
        end else if (inst_req) begin
          state_nxt = INST;
          req_nxt   = 1'b1;
          sel_nxt   = 1'b0;
          we_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      end
      DATA, INST: begin
        // mem_sel keeps its last value so the address mux does not glitch
        if (mem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
      end
    endcase
  end

  assign data_done  = (state == DATA) && mem_ack;
  assign inst_done  = (state == INST) && mem_ack;
  assign inst_stall = inst_req && !inst_done;
  assign data_stall = data_req && !data_done;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic clk, rst_n;
  logic inst_req, data_req, data_we, mem_ack;
  logic mem_req, mem_we, mem_sel, inst_done, data_done, inst_stall, data_stall, busy;
  logic i0_req, d0_req, d0_we, ack0;
  logic mem_req0, mem_we0, mem_sel0, inst_done0, data_done0, inst_stall0, data_stall0, busy0;

  int tests, fails;

  // memory responder controls
  bit resp_en, rand_lat, stale_en, man_ack;
  int fixed_lat, cur_lat, acc_cyc;

  mem_port_arbiter #(.STARVE_LIMIT(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .inst_req(inst_req), .data_req(data_req), .data_we(data_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_ack(mem_ack),
    .inst_done(inst_done), .data_done(data_done), .inst_stall(inst_stall),
    .data_stall(data_stall), .busy(busy)
  );

  mem_port_arbiter #(.STARVE_LIMIT(0), .CNT_W(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .inst_req(i0_req), .data_req(d0_req), .data_we(d0_we),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_sel(mem_sel0), .mem_ack(ack0),
    .inst_done(inst_done0), .data_done(data_done0), .inst_stall(inst_stall0),
    .data_stall(data_stall0), .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  // Memory model: acks after cur_lat cycles of mem_req, optional stale acks while idle
  initial begin
    mem_ack = 1'b0;
    acc_cyc = 0;
    cur_lat = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        mem_ack = man_ack;
        acc_cyc = 0;
      end else if (mem_req) begin
        if (acc_cyc == 0) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
        acc_cyc++;
        mem_ack = (acc_cyc == cur_lat);
      end else begin
        acc_cyc = 0;
        mem_ack = stale_en && ($urandom_range(0, 5) == 0);
      end
    end
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; man_ack = 1'b0;
    i0_req = 1'b0; d0_req = 1'b0; d0_we = 1'b0; ack0 = 1'b0;
    @(negedge clk);
    check("reset", {mem_req, mem_we, mem_sel, busy, inst_done, data_done, inst_stall, data_stall}, 16'h0);
    check("reset0", {mem_req0, mem_we0, mem_sel0, busy0, inst_done0, data_done0, inst_stall0,
                     data_stall0}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic ir, dr, we;
    logic exp_req, exp_sel, exp_we;
  } vec_t;

  vec_t vecs [6];
  bit   ok;
  int   ndone;
  // reference model state for the random run
  int   m_owner, m_cnt;
  logic m_sel, m_we;
  logic e_id, e_dd;
  bit   idone_seen, ddone_seen;

  initial begin
    tests = 0; fails = 0;
    resp_en = 1'b1; rand_lat = 1'b0; stale_en = 1'b0; fixed_lat = 1; man_ack = 1'b0;
    rst_n = 1'b1;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // single-grant vectors from a fresh reset, latency 1
    for (int i = 0; i < 6; i++) begin
      do_reset();
      @(posedge clk); #1;
      inst_req = vecs[i].ir; data_req = vecs[i].dr; data_we = vecs[i].we;
      @(negedge clk);
      check("vec_idle", {inst_stall, data_stall, mem_req}, {vecs[i].ir, vecs[i].dr, 1'b0});
      @(negedge clk);
      check("vec_grant", {mem_req, mem_sel, mem_we}, {vecs[i].exp_req, vecs[i].exp_sel, vecs[i].exp_we});
      check("vec_done", {inst_done, data_done},
            {vecs[i].exp_req && !vecs[i].exp_sel, vecs[i].exp_req && vecs[i].exp_sel});
      @(posedge clk); #1;
      inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    end

    // fetch alone, latency 2
    do_reset();
    fixed_lat = 2;
    @(posedge clk); #1; inst_req = 1'b1;
    @(negedge clk);
    check("f_idle", {mem_req, inst_stall, busy}, 3'b010);
    @(negedge clk);
    check("f_cyc1", {mem_req, mem_sel, mem_we, inst_done, inst_stall, busy}, 6'b100011);
    @(negedge clk);
    check("f_cyc2", {mem_req, mem_sel, mem_we, inst_done, inst_stall, busy}, 6'b100101);
    @(posedge clk); #1; inst_req = 1'b0;
    @(negedge clk);
    check("f_after", {mem_req, busy, inst_done}, 3'b000);

    // both requesting, data re-requests: DATA, DATA, INST
    do_reset();
    fixed_lat = 1;
    @(posedge clk); #1; inst_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      check("starve_wait", {15'h0, ok}, 16'h1);
      check("starve_sel", mem_sel, (k < 2));
      check("starve_done", {inst_done, data_done}, (k < 2) ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1; inst_req = 1'b0; data_req = 1'b0;

    // store with data_we toggled mid-access, latency 3
    do_reset();
    fixed_lat = 3;
    @(posedge clk); #1; data_req = 1'b1; data_we = 1'b1;
    wait_req(ok);
    check("st_wait", {15'h0, ok}, 16'h1);
    check("st_cyc1", {mem_sel, mem_we, data_done}, 3'b110);
    @(posedge clk); #1; data_we = 1'b0;
    @(negedge clk);
    check("st_cyc2", {mem_sel, mem_we, data_done}, 3'b110);
    @(negedge clk);
    check("st_cyc3", {mem_sel, mem_we, data_done, data_stall}, 4'b1110);
    @(posedge clk); #1; data_req = 1'b0;
    @(negedge clk);
    check("st_after", {mem_req, mem_we, mem_sel, busy}, 4'b0010);

    // STARVE_LIMIT=0 instance: fetch first, then data
    do_reset();
    @(posedge clk); #1; i0_req = 1'b1; d0_req = 1'b1;
    @(negedge clk);
    check("sl0_idle", mem_req0, 1'b0);
    @(negedge clk);
    check("sl0_first", {mem_req0, mem_sel0}, 2'b10);
    @(posedge clk); #1; ack0 = 1'b1;
    @(negedge clk);
    check("sl0_idone", {inst_done0, data_done0}, 2'b10);
    @(posedge clk); #1; ack0 = 1'b0; i0_req = 1'b0;
    @(negedge clk);
    check("sl0_bubble", mem_req0, 1'b0);
    @(negedge clk);
    check("sl0_second", {mem_req0, mem_sel0}, 2'b11);
    @(posedge clk); #1; ack0 = 1'b1;
    @(negedge clk);
    check("sl0_ddone", {inst_done0, data_done0}, 2'b01);
    @(posedge clk); #1; ack0 = 1'b0; d0_req = 1'b0;

    // reset mid-access, then a stale ack in IDLE
    do_reset();
    resp_en = 1'b0; man_ack = 1'b0;
    @(posedge clk); #1; data_req = 1'b1; data_we = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre", {mem_req, mem_sel, mem_we, busy}, 4'b1111);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async", {mem_req, mem_we, mem_sel, busy, data_done}, 5'b0);
    check("rst_stall", data_stall, 1'b1);
    data_req = 1'b0; data_we = 1'b0; man_ack = 1'b1;
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    check("stale1", {mem_ack, data_done, inst_done, busy, mem_req}, 5'b10000);
    @(negedge clk);
    check("stale2", {data_done, inst_done, busy, mem_req}, 4'b0000);
    man_ack = 1'b0; resp_en = 1'b1;

    // back-to-back fetches, request held, latency 1
    do_reset();
    fixed_lat = 1;
    ndone = 0;
    @(posedge clk); #1; inst_req = 1'b1;
    @(negedge clk);
    check("b2b_idle", mem_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_req", {mem_req, mem_sel}, {(k % 2) == 0, 1'b0});
      if (inst_done) ndone++;
    end
    check("b2b_ndone", 16'(ndone), 16'd2);

    // randomized run against the reference model
    do_reset();
    rand_lat = 1'b1; stale_en = 1'b1;
    m_owner = 0; m_cnt = 0; m_sel = 1'b0; m_we = 1'b0;
    idone_seen = 1'b0; ddone_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      if (inst_req) begin
        if (idone_seen) inst_req = 1'($urandom_range(0, 1));
      end else inst_req = ($urandom_range(0, 2) == 0);
      if (data_req) begin
        if (ddone_seen) data_req = 1'($urandom_range(0, 1));
      end else data_req = ($urandom_range(0, 2) == 0);
      data_we = 1'($urandom_range(0, 1));
      @(negedge clk);
      e_id = (m_owner == 2) && mem_ack;
      e_dd = (m_owner == 1) && mem_ack;
      check("rand", {mem_req, mem_sel, mem_we, inst_done, data_done, inst_stall, data_stall, busy},
            {m_owner != 0, m_sel, m_we, e_id, e_dd, inst_req && !e_id, data_req && !e_dd, m_owner != 0});
      idone_seen = e_id;
      ddone_seen = e_dd;
      if (m_owner == 0) begin
        if (data_req && (!inst_req || m_cnt < 2)) begin
          m_owner = 1; m_sel = 1'b1; m_we = data_we;
          m_cnt = inst_req ? ((m_cnt + 1 > 2) ? 2 : m_cnt + 1) : 0;
        end else if (inst_req) begin
          m_owner = 2; m_sel = 1'b0; m_we = 1'b0; m_cnt = 0;
        end
      end else if (mem_ack) begin
        m_owner = 0; m_we = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
